// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: AES inverse SubBytes over a 4-column state with a
// valid/ready handshake on both sides.
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   w0_curr..w3_curr      input state columns, byte [31:24] is row 0
//   in_valid / in_ready   input handshake; in_ready is high in idle only
//   w0_next..w3_next      substituted columns, always the internal register
//   out_valid / out_ready output handshake; out_valid is high in done only
//
// Build option:
//   INV_SUB_BYTES_PARALLEL_EN  defined: substitute all 16 bytes in one busy
//                              edge; undefined: one column per busy edge.
module inv_sub_bytes_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] w0_curr,
    input  logic [31:0] w1_curr,
    input  logic [31:0] w2_curr,
    input  logic [31:0] w3_curr,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] w0_next,
    output logic [31:0] w1_next,
    output logic [31:0] w2_next,
    output logic [31:0] w3_next,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    // Entry i sits at bits [(255-i)*8 +: 8], i.e. first listed is entry 0.
    localparam logic [2047:0] InvSbox = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        // (255 - b) * 8 == {~b, 3'b000}
        return InvSbox[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {inv_sbox(w[31:24]), inv_sbox(w[23:16]), inv_sbox(w[15:8]), inv_sbox(w[7:0])};
    endfunction

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [3:0][31:0] w_q, w_d;   // w_q[0] holds column w0

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            w_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        w_d       = w_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_d[0]  = w0_curr;
                    w_d[1]  = w1_curr;
                    w_d[2]  = w2_curr;
                    w_d[3]  = w3_curr;
                    cnt_d   = 2'd0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
`ifdef INV_SUB_BYTES_PARALLEL_EN
                for (int i = 0; i < 4; i++) begin
                    w_d[i] = sub_word(w_q[i]);
                end
                state_d = StDone;
`else
                w_d[cnt_q] = sub_word(w_q[cnt_q]);
                cnt_d      = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = StDone;
                end
`endif
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign w0_next = w_q[0];
    assign w1_next = w_q[1];
    assign w2_next = w_q[2];
    assign w3_next = w_q[3];

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
module tb_inv_sub_bytes_seq;

`ifdef INV_SUB_BYTES_PARALLEL_EN
    localparam int Lat = 1;
`else
    localparam int Lat = 4;
`endif
    localparam int Period = Lat + 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] w0_curr = '0, w1_curr = '0, w2_curr = '0, w3_curr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] w0_next, w1_next, w2_next, w3_next;
    logic        out_valid;
    logic        out_ready = 1'b1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int last_accept = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   ref_inv[256];

    inv_sub_bytes_seq dut (
        .clk      (clk),
        .reset    (reset),
        .w0_curr  (w0_curr),
        .w1_curr  (w1_curr),
        .w2_curr  (w2_curr),
        .w3_curr  (w3_curr),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .w0_next  (w0_next),
        .w1_next  (w1_next),
        .w2_next  (w2_next),
        .w3_next  (w3_next),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: build the forward S-box from GF(2^8) inversion plus the
    // affine map, then invert the permutation.
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a = a_in;
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
        logic [7:0] inv = 8'h01;
        logic [7:0] r;
        logic [7:0] s;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        if (x == 8'h00) inv = 8'h00;
        s = inv;
        r = inv;
        for (int k = 0; k < 4; k++) begin
            r = {r[6:0], r[7]};
            s = s ^ r;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] d);
        logic [127:0] o;
        for (int p = 0; p < 16; p++) o[p*8 +: 8] = ref_inv[d[p*8 +: 8]];
        return o;
    endfunction

    function automatic logic [127:0] outs();
        return {w0_next, w1_next, w2_next, w3_next};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called shortly after a rising edge; returns #1 after the accept edge.
    task automatic send(input logic [127:0] d, input logic [127:0] exp);
        int g = 0;
        while (!in_ready && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("in_ready_wait", {127'd0, in_ready}, 128'd1);
        {w0_curr, w1_curr, w2_curr, w3_curr} = d;
        in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(exp);
        last_accept = cyc;
        #1;
        in_valid = 1'b0;
        {w0_curr, w1_curr, w2_curr, w3_curr} = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_out_valid(output int k);
        k = 0;
        while (!out_valid && k < 50) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    // Monitor: the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_out: got %h expected no result", outs());
            end else begin
                logic [127:0] e;
                e = exp_q.pop_front();
                if (outs() !== e) begin
                    n_err++;
                    $display("FAIL result: got %h expected %h", outs(), e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] d, e;
        int k, prev;

        for (int x = 0; x < 256; x++) ref_inv[fwd_sbox(8'(x))] = 8'(x);

        // Reset state
        @(posedge clk);
        #1;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_outputs", outs(), 128'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // All-zero state and latency
        send(128'd0, {4{32'h52525252}});
        wait_out_valid(k);
        chk("latency_zero", 128'(k), 128'(Lat));
        @(posedge clk);
        #1;

        // Known vector
        send({32'h63637C7C, 32'hFF000163, 32'h01010101, 32'hFFFFFFFF},
             {32'h00000101, 32'h7D520900, 32'h09090909, 32'h7D7D7D7D});
        wait_out_valid(k);
        chk("latency_vec", 128'(k), 128'(Lat));

        // Random patterns
        for (int t = 0; t < 20; t++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            send(d, model(d));
        end

        // Backpressure in DONE with in_valid noise
        wait_out_valid(k);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        e = model(d);
        send(d, e);
        wait_out_valid(k);
        chk("bp_out_valid", {127'd0, out_valid}, 128'd1);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            {w0_curr, w1_curr, w2_curr, w3_curr} = {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk);
            #1;
            chk("bp_in_ready", {127'd0, in_ready}, 128'd0);
            chk("bp_out_valid_hold", {127'd0, out_valid}, 128'd1);
            chk("bp_stable", outs(), e);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", {126'd0, in_ready, out_valid}, 128'd2);

        // Reset mid-BUSY
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, model(d));
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("arst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("arst_outputs", outs(), 128'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        d = {$urandom, $urandom, $urandom, $urandom};
        send(d, model(d));
        wait_out_valid(k);
        chk("post_rst_latency", 128'(k), 128'(Lat));
        @(posedge clk);
        #1;

        // Back-to-back sweep: every byte value in every position
        prev = 0;
        for (int t = 0; t < 256; t++) begin
            for (int p = 0; p < 16; p++) d[p*8 +: 8] = 8'(t + p * 37);
            send(d, model(d));
            if (t > 0) chk("throughput", 128'(last_accept - prev), 128'(Period));
            prev = last_accept;
        end

        k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        #1;
        chk("drain", 128'(exp_q.size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
